// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: guarded digit slots, frame-aligned
// commit of staged BCD data, leading-zero blanking and BCD error flag.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    input  logic [7:0]              seg_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    ack,
    output logic                    bcd_err
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GUARD = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stage_val;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    pending;

    logic                    frame_wrap;
    logic                    commit_ok;
    logic                    commit_load;
    logic                    commit_stage;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic                    blank;
    logic                    seg_dp_unused;

    // Commits happen only at a frame boundary or while the display is dark,
    // so a digit never shows a mix of old and new data.
    assign frame_wrap   = (state == S_DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign commit_ok    = (state == S_IDLE) || (enable && frame_wrap);
    assign commit_load  = commit_ok && load;
    assign commit_stage = commit_ok && pending && !load;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            stage_val <= '0;
            stage_dp  <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
            ack       <= 1'b0;
        end else begin
            if (!enable) begin
                state <= S_IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_GUARD;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                    S_GUARD: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == GUARD_LAST)
                            state <= S_DRIVE;
                    end
                    S_DRIVE: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                            state <= S_GUARD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                endcase
            end

            ack <= commit_load || commit_stage;
            if (commit_load) begin
                disp_val <= value_in;
                disp_dp  <= dp_in;
                pending  <= 1'b0;
            end else if (commit_stage) begin
                disp_val <= stage_val;
                disp_dp  <= stage_dp;
                pending  <= 1'b0;
            end else if (load) begin
                stage_val <= value_in;
                stage_dp  <= dp_in;
                pending   <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default before any branch,
    // otherwise an untaken path would infer a latch.
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        bcd_err = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (disp_val[i*4 +: 4] == 4'd0);
            lz_mask[i] = lz_run;
            if (disp_val[i*4 +: 4] > 4'd9)
                bcd_err = 1'b1;
        end
    end

    assign blank   = blank_lz && (idx != '0) && lz_mask[idx] && !disp_dp[idx];
    assign bcd_out = disp_val[{idx, 2'b00} +: 4];

    // The decoder's own dp bit is ignored; the lit state comes from disp_dp.
    assign seg_dp_unused = seg_in[7];
    assign seg_out = (state == S_IDLE) ? 8'hFF : {~disp_dp[idx], seg_in[6:0]};

    always_comb begin
        an = '1;
        if (state == S_DRIVE && !blank)
            an[idx] = 1'b0;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-cycle slots, 1 guard cycle.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset, enable, load, blank_lz;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [7:0]  seg_in;
    logic [3:0]  bcd_out;
    logic [7:0]  seg_out;
    logic [3:0]  an;
    logic        ack, bcd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYC(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .value_in(value_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .bcd_out(bcd_out), .seg_in(seg_in), .seg_out(seg_out),
        .an(an), .ack(ack), .bcd_err(bcd_err)
    );

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [7:0]  seg;
        logic [3:0]  x_an;
        logic [3:0]  x_bcd;
        logic [7:0]  x_seg;
        logic        x_ack;
        logic        x_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        return v[d*4 +: 4];
    endfunction

    function automatic vec_t mk(input logic en, input logic ld, input logic [15:0] val,
                                input logic [3:0] dp, input logic [7:0] seg,
                                input logic [3:0] x_an, input logic [3:0] x_bcd,
                                input logic [7:0] x_seg, input logic x_ack, input logic x_err);
        vec_t v;
        v.en = en; v.ld = ld; v.val = val; v.dp = dp; v.seg = seg;
        v.x_an = x_an; v.x_bcd = x_bcd; v.x_seg = x_seg; v.x_ack = x_ack; v.x_err = x_err;
        return v;
    endfunction

    // Reset, load while idle (commits immediately), enable; leaves the scan at
    // frame position 0 (digit 0, guard cycle).
    task automatic start_scan(input logic [15:0] val, input logic [3:0] dp, input logic blz);
        reset = 1'b1; enable = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; blank_lz = blz;
        tick(); tick();
        reset = 1'b0;
        load = 1'b1; value_in = val; dp_in = dp;
        tick();
        load = 1'b0;
        check("start_ack", ack, 1'b1);
        enable = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] exp_val;
        logic [3:0]  an_blank [4];
        logic [3:0]  an_dp    [4];
        int          ack_cnt;

        seg_in = 8'h95; blank_lz = 1'b0; dp_in = '0;

        // Reset has priority over load/enable.
        reset = 1'b1; enable = 1'b1; load = 1'b1; value_in = 16'hFFFF;
        tick();
        check("rst_an", an, 4'hF);
        check("rst_bcd", bcd_out, 4'h0);
        check("rst_seg", seg_out, 8'hFF);
        check("rst_ack", ack, 1'b0);
        check("rst_err", bcd_err, 1'b0);
        tick();
        check("rst_ack2", ack, 1'b0);
        reset = 1'b0; enable = 1'b0; load = 1'b0; value_in = '0;

        // Scan table: load 0x1234 with dp on digit 1, then one full frame.
        tbl.push_back(mk(0, 1, 16'h1234, 4'b0010, 8'h95, 4'hF, 4'h0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 4'b0000, 8'h95, 4'hF, 4'h4, 8'hFF, 1, 0));
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] s;
                logic [7:0] xs;
                logic [3:0] xa;
                s  = 8'h80 | 8'(d * 16 + c + 1);
                xs = {(d != 1), s[6:0]};
                xa = (c == 0) ? 4'hF : ~(4'b0001 << d);
                tbl.push_back(mk(1, 0, 16'h0000, 4'b0000, s, xa, nib(16'h1234, d), xs, 0, 0));
            end
        end
        tbl.push_back(mk(1, 0, 16'h0000, 4'b0000, 8'hA5, 4'hF, 4'h4, 8'hA5, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            enable = tbl[i].en; load = tbl[i].ld; value_in = tbl[i].val;
            dp_in = tbl[i].dp; seg_in = tbl[i].seg;
            #1;
            check($sformatf("scan%0d_an", i), an, tbl[i].x_an);
            check($sformatf("scan%0d_bcd", i), bcd_out, tbl[i].x_bcd);
            check($sformatf("scan%0d_seg", i), seg_out, tbl[i].x_seg);
            check($sformatf("scan%0d_ack", i), ack, tbl[i].x_ack);
            check($sformatf("scan%0d_err", i), bcd_err, tbl[i].x_err);
            tick();
        end
        load = 1'b0; seg_in = 8'h95;

        // Tear: load mid-frame at digit 1, new data appears only after wrap.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (5) tick();
        load = 1'b1; value_in = 16'h5678;
        tick();
        load = 1'b0;
        for (int p = 6; p <= 32; p++) begin
            exp_val = (p < 16) ? 16'h1234 : 16'h5678;
            check($sformatf("tear_bcd_p%0d", p), bcd_out, nib(exp_val, (p / 4) % 4));
            check($sformatf("tear_ack_p%0d", p), ack, (p == 16));
            tick();
        end

        // Blanking: only digit 0 driven; with dp on digit 2 it is driven too.
        an_blank = '{4'hE, 4'hF, 4'hF, 4'hF};
        an_dp    = '{4'hE, 4'hF, 4'hB, 4'hF};
        start_scan(16'h0007, 4'b0000, 1'b1);
        for (int p = 0; p < 16; p++) begin
            check($sformatf("blank_an_p%0d", p), an, (p % 4 == 0) ? 4'hF : an_blank[p / 4]);
            tick();
        end
        start_scan(16'h0007, 4'b0100, 1'b1);
        for (int p = 0; p < 16; p++) begin
            check($sformatf("blankdp_an_p%0d", p), an, (p % 4 == 0) ? 4'hF : an_dp[p / 4]);
            check($sformatf("blankdp_seg7_p%0d", p), seg_out[7], (p / 4 != 2));
            tick();
        end
        blank_lz = 1'b0;

        // Collision: two loads before wrap, a third on the wrap cycle.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (3) tick();
        ack_cnt = 0;
        for (int p = 3; p <= 31; p++) begin
            load = (p == 3) || (p == 7) || (p == 15);
            value_in = (p == 3) ? 16'h1111 : (p == 7) ? 16'h2222 : 16'h3333;
            #1;
            if (ack === 1'b1)
                ack_cnt++;
            if (p >= 16)
                check($sformatf("coll_bcd_p%0d", p), bcd_out, 4'h3);
            tick();
        end
        load = 1'b0;
        check("coll_ack_count", ack_cnt, 1);

        // Enable drop mid-DRIVE blanks immediately and returns to digit 0.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (6) tick();
        check("en_drive_an", an, 4'hD);
        check("en_drive_bcd", bcd_out, 4'h3);
        enable = 1'b0;
        tick();
        check("en_off_an", an, 4'hF);
        check("en_off_seg", seg_out, 8'hFF);
        check("en_off_bcd", bcd_out, 4'h4);

        // Reset with pending data: nothing commits afterwards.
        start_scan(16'h1234, 4'b0000, 1'b0);
        repeat (5) tick();
        load = 1'b1; value_in = 16'h5678;
        tick();
        load = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rstp_ack_%0d", k), ack, 1'b0);
            check($sformatf("rstp_bcd_%0d", k), bcd_out, 4'h0);
            check($sformatf("rstp_err_%0d", k), bcd_err, 1'b0);
            check($sformatf("rstp_an_%0d", k), an, 4'hF);
            tick();
        end
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rstp_run_bcd_%0d", k), bcd_out, 4'h0);
            check($sformatf("rstp_run_ack_%0d", k), ack, 1'b0);
        end

        // BCD error flag follows the committed value.
        start_scan(16'h00A0, 4'b0000, 1'b0);
        check("err_set", bcd_err, 1'b1);
        check("err_bcd0", bcd_out, 4'h0);
        repeat (4) tick();
        check("err_bcd1", bcd_out, 4'hA);
        tick();
        load = 1'b1; value_in = 16'h0000;
        tick();
        load = 1'b0;
        for (int p = 6; p <= 17; p++) begin
            check($sformatf("err_flag_p%0d", p), bcd_err, (p < 16));
            check($sformatf("err_ack_p%0d", p), ack, (p == 16));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (>= GUARD_CYC+2).
REQ-003 The block SHALL have parameter GUARD_CYC, default 2, giving the cycles at slot start with all anodes off (anti-ghosting).
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1; high runs the scan, low blanks the display.
REQ-007 The block SHALL have port load, input, 1, a single-cycle request to stage value_in/dp_in.
REQ-008 The block SHALL have port value_in, input, 4*NUM_DIGITS, packed BCD; nibble i is digit i, digit 0 least significant.
REQ-009 The block SHALL have port dp_in, input, NUM_DIGITS, decimal point per digit, 1 = lit.
REQ-010 The block SHALL have port blank_lz, input, 1; high enables leading-zero blanking.
REQ-011 The block SHALL have port bcd_out, output, 4, the digit code driven to the shared BCD-to-7-segment decoder.
REQ-012 The block SHALL have port seg_in, input, 8, the active-low decoder output for bcd_out (bit 7 = dp, returned as 1).
REQ-013 The block SHALL have port seg_out, output, 8, active-low segments to the pins.
REQ-014 The block SHALL have port an, output, NUM_DIGITS, active-low digit anodes.
REQ-015 The block SHALL have port ack, output, 1, a one-cycle pulse when staged data is committed to the display.
REQ-016 The block SHALL have port bcd_err, output, 1, high while any committed nibble is greater than 9.

Function
REQ-017 The FSM SHALL have states IDLE, GUARD and DRIVE; IDLE->GUARD when enable=1; GUARD->DRIVE after GUARD_CYC cycles; DRIVE->GUARD at slot end; any state->IDLE when enable=0 (checked first).
REQ-018 A slot counter SHALL count 0..REFRESH_DIV-1 in GUARD/DRIVE; at REFRESH_DIV-1 the counter SHALL wrap to 0 and the digit index SHALL advance, NUM_DIGITS-1 wrapping to 0.
REQ-019 In IDLE the slot counter and digit index SHALL be held at 0, an SHALL be all ones, and seg_out SHALL be 8'hFF.
REQ-020 In GUARD an SHALL be all ones; in DRIVE an[idx] SHALL be 0 unless digit idx is blanked, and all other bits SHALL be 1.
REQ-021 bcd_out SHALL equal committed nibble idx in all states and SHALL update on the same cycle as idx.
REQ-022 seg_out SHALL be {~dp[idx], seg_in[6:0]} in GUARD/DRIVE, combinational from seg_in.
REQ-023 Digit idx SHALL be blanked when blank_lz=1, idx != 0, committed nibbles idx..NUM_DIGITS-1 are all 0, and dp[idx]=0.
REQ-024 load=1 SHALL write value_in/dp_in into the staging register and set pending; a load while pending SHALL overwrite staging with a single ack.
REQ-025 Commit SHALL occur on the cycle the digit index wraps NUM_DIGITS-1->0 with pending=1: staging is copied to committed, pending clears, and ack=1 for exactly that cycle.
REQ-026 A load coinciding with a commit cycle SHALL commit value_in/dp_in directly, clear pending and pulse ack once.
REQ-027 In IDLE a pending load SHALL commit on the next cycle with an ack pulse, with no tearing risk.
REQ-028 Invalid nibbles (>9) SHALL pass unchanged to bcd_out; bcd_err SHALL reflect the committed value combinationally.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, idx=0, slot counter=0, staging=0, committed=0, dp=0, pending=0, ack=0, an=all ones, bcd_out=0, seg_out=8'hFF, bcd_err=0.
REQ-030 Reset SHALL take priority over load and enable in the same cycle; a reset mid-slot SHALL abandon the slot and drop pending data.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1)
REQ-031 Scan check: reset, enable=1, load value 0x1234 -> ack within 1 cycle; an sequence 1111,1110 (3 cycles), 1111,1101..., bcd_out 4,3,2,1 repeating every 16 cycles.
REQ-032 Tear check: load 0x5678 mid-frame at idx=1 -> bcd_out stays on old digits until wrap to idx 0; ack on the wrap cycle only; next frame shows 8,7,6,5.
REQ-033 Blanking check: committed 0x0007, blank_lz=1 -> only an[0] ever low; with dp_in=4'b0100 -> an[2] also low and seg_out[7]=0 in slot 2.
REQ-034 Collision check: double load (0x1111, then 0x2222) before wrap, plus load 0x3333 on the wrap cycle -> exactly one ack and 0x3333 displayed.
REQ-035 Enable/reset check: drop enable mid-DRIVE -> an=1111 and seg_out=FF next cycle, idx=0; reset with pending=1 -> no ack, display 0, bcd_err=0.
REQ-036 Error check: load 0x00A0 -> bcd_err=1 after commit, bcd_out=A in slot 1; load 0x0000 -> bcd_err=0 after commit.
